// File: rtl/fft_pkg.sv
// Shared constants and arithmetic helpers for the streaming 4-point FFT.
// Helpers work on 64-bit signed values so callers can use any width up to that.
package fft_pkg;

    localparam int DW_DEFAULT = 16;

    localparam logic [1:0] ROT_NONE  = 2'd0;
    localparam logic [1:0] ROT_NEG_J = 2'd1;
    localparam logic [1:0] ROT_POS_J = 2'd2;

    function automatic logic signed [63:0] rnd_shr1(input logic signed [63:0] v);
        return (v + 64'sd1) >>> 1;
    endfunction

    function automatic logic signed [63:0] sat_dw(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Component offset inside in_x/out_X: bin k real at 2k, imaginary at 2k+1.
    function automatic int comp_lo(input int bin, input int im, input int w);
        return (2 * bin + im) * w;
    endfunction

endpackage

// File: rtl/fft_bfly2.sv
// Complex radix-2 butterfly: p + rot(q) and p - rot(q), rot in {1, -j, +j},
// with optional rounded halving (saturated back to IW bits) for the scaled mode.
module fft_bfly2
    import fft_pkg::*;
#(
    parameter int IW    = 16,
    parameter bit SCALE = 1'b0,
    parameter int OW    = SCALE ? IW : IW + 1
) (
    input  logic signed [IW-1:0] i_p_re,
    input  logic signed [IW-1:0] i_p_im,
    input  logic signed [IW-1:0] i_q_re,
    input  logic signed [IW-1:0] i_q_im,
    input  logic [1:0]           i_rot,
    output logic signed [OW-1:0] o_sum_re,
    output logic signed [OW-1:0] o_sum_im,
    output logic signed [OW-1:0] o_dif_re,
    output logic signed [OW-1:0] o_dif_im
);

    logic signed [IW:0]   w_qr_re;
    logic signed [IW:0]   w_qr_im;
    logic signed [IW+1:0] w_res [4];
    logic signed [OW-1:0] w_out [4];

    // Rotation is done one bit wider so negating the most negative value cannot wrap.
    always_comb begin
        w_qr_re = (IW+1)'(i_q_re);
        w_qr_im = (IW+1)'(i_q_im);
        case (i_rot)
            ROT_NEG_J: begin
                w_qr_re = (IW+1)'(i_q_im);
                w_qr_im = -((IW+1)'(i_q_re));
            end
            ROT_POS_J: begin
                w_qr_re = -((IW+1)'(i_q_im));
                w_qr_im = (IW+1)'(i_q_re);
            end
            default: ;
        endcase
    end

    assign w_res[0] = (IW+2)'(i_p_re) + (IW+2)'(w_qr_re);
    assign w_res[1] = (IW+2)'(i_p_im) + (IW+2)'(w_qr_im);
    assign w_res[2] = (IW+2)'(i_p_re) - (IW+2)'(w_qr_re);
    assign w_res[3] = (IW+2)'(i_p_im) - (IW+2)'(w_qr_im);

    for (genvar k = 0; k < 4; k++) begin : g_out
        if (SCALE) begin : g_scale
            assign w_out[k] = OW'(sat_dw(rnd_shr1(64'(w_res[k])), IW));
        end else begin : g_full
            assign w_out[k] = OW'(w_res[k]);
        end
    end

    assign o_sum_re = w_out[0];
    assign o_sum_im = w_out[1];
    assign o_dif_re = w_out[2];
    assign o_dif_im = w_out[3];

endmodule

// File: rtl/fft4_stream.sv
// Streaming 4-point FFT/IFFT: two butterfly stages plus a saturating output register,
// one frame per clock, the whole pipeline stalling together under output backpressure.
module fft4_stream
    import fft_pkg::*;
#(
    parameter int DW       = DW_DEFAULT,
    parameter bit SCALE_EN = 1'b1,
    parameter int TAG_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_inv,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [8*DW-1:0]   in_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [8*DW-1:0]   out_X,
    output logic              out_inv,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_ovf
);

    localparam int W1 = SCALE_EN ? DW : DW + 1;
    localparam int W2 = SCALE_EN ? DW : DW + 2;

    // Stage arrays: S1 holds a,b,c,d (re,im pairs); S2 holds X0..X3 in out_X order.
    logic signed [DW-1:0] w_x  [8];
    logic signed [W1-1:0] w_s1 [8];
    logic signed [W2-1:0] w_s2 [8];
    logic signed [W1-1:0] r_s1 [8];
    logic signed [W2-1:0] r_s2 [8];

    logic              w_adv;
    logic [1:0]        w_rot;
    logic [7:0]        w_clip;
    logic [8*DW-1:0]   w_sat_x;
    logic              r_v1, r_v2, r_out_valid;
    logic              r_inv1, r_inv2, r_out_inv, r_out_ovf;
    logic [TAG_W-1:0]  r_tag1, r_tag2, r_out_tag;
    logic [8*DW-1:0]   r_out_x;

    for (genvar c = 0; c < 8; c++) begin : g_unpack
        assign w_x[c] = in_x[comp_lo(c / 2, c % 2, DW) +: DW];
    end

    fft_bfly2 #(.IW(DW), .SCALE(SCALE_EN), .OW(W1)) u_s1_02 (
        .i_p_re(w_x[0]), .i_p_im(w_x[1]), .i_q_re(w_x[4]), .i_q_im(w_x[5]), .i_rot(ROT_NONE),
        .o_sum_re(w_s1[0]), .o_sum_im(w_s1[1]), .o_dif_re(w_s1[2]), .o_dif_im(w_s1[3]));

    fft_bfly2 #(.IW(DW), .SCALE(SCALE_EN), .OW(W1)) u_s1_13 (
        .i_p_re(w_x[2]), .i_p_im(w_x[3]), .i_q_re(w_x[6]), .i_q_im(w_x[7]), .i_rot(ROT_NONE),
        .o_sum_re(w_s1[4]), .o_sum_im(w_s1[5]), .o_dif_re(w_s1[6]), .o_dif_im(w_s1[7]));

    // Odd bins: forward uses b -/+ j*d, inverse swaps the rotation sign.
    assign w_rot = r_inv1 ? ROT_POS_J : ROT_NEG_J;

    fft_bfly2 #(.IW(W1), .SCALE(SCALE_EN), .OW(W2)) u_s2_ac (
        .i_p_re(r_s1[0]), .i_p_im(r_s1[1]), .i_q_re(r_s1[4]), .i_q_im(r_s1[5]), .i_rot(ROT_NONE),
        .o_sum_re(w_s2[0]), .o_sum_im(w_s2[1]), .o_dif_re(w_s2[4]), .o_dif_im(w_s2[5]));

    fft_bfly2 #(.IW(W1), .SCALE(SCALE_EN), .OW(W2)) u_s2_bd (
        .i_p_re(r_s1[2]), .i_p_im(r_s1[3]), .i_q_re(r_s1[6]), .i_q_im(r_s1[7]), .i_rot(w_rot),
        .o_sum_re(w_s2[2]), .o_sum_im(w_s2[3]), .o_dif_re(w_s2[6]), .o_dif_im(w_s2[7]));

    for (genvar c = 0; c < 8; c++) begin : g_sat
        logic signed [63:0] w_wide;
        assign w_wide     = sat_dw(64'(r_s2[c]), DW);
        assign w_clip[c]  = (w_wide != 64'(r_s2[c]));
        assign w_sat_x[c*DW +: DW] = DW'(w_wide);
    end

    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = w_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_x     <= '0;
            r_out_inv   <= 1'b0;
            r_out_tag   <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_adv) begin
            r_v1        <= in_valid;
            r_v2        <= r_v1;
            r_out_valid <= r_v2;
            r_out_x     <= w_sat_x;
            r_out_inv   <= r_inv2;
            r_out_tag   <= r_tag2;
            r_out_ovf   <= |w_clip;
        end
    end

    // Payload of the inner stages needs no reset: the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_s1   <= w_s1;
            r_inv1 <= in_inv;
            r_tag1 <= in_tag;
            r_s2   <= w_s2;
            r_inv2 <= r_inv1;
            r_tag2 <= r_tag1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_X     = r_out_x;
    assign out_inv   = r_out_inv;
    assign out_tag   = r_out_tag;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_fft4_stream.sv
// Bench for fft4_stream: a full-growth and a scaled instance share one input stream and
// are compared every output handshake against a DFT-level reference model.
`timescale 1ns/1ps
module tb_fft4_stream;

    localparam int DW    = 16;
    localparam int TAG_W = 4;
    localparam int FW    = 8 * DW;
    localparam int MAXV  = (1 << (DW - 1)) - 1;
    localparam int MINV  = -(1 << (DW - 1));

    typedef struct {
        logic [FW-1:0]    x;
        logic             inv;
        logic [TAG_W-1:0] tag;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_inv = 1'b0;
    logic             out_ready = 1'b1;
    logic [TAG_W-1:0] in_tag = '0;
    logic [FW-1:0]    in_x = '0;

    logic             rdy0, rdy1, ov0, ov1, inv0, inv1, ovf0, ovf1;
    logic [FW-1:0]    x0Out, x1Out;
    logic [TAG_W-1:0] tag0, tag1;

    int               total = 0;
    int               bad = 0;
    exp_t             q0[$];
    exp_t             q1[$];
    logic [TAG_W-1:0] tagLog[$];
    logic             prevStall = 1'b0;
    logic [FW-1:0]    prevX = '0;
    logic [TAG_W-1:0] prevTag = '0;
    logic             randDone = 1'b0;

    always #5 clk = ~clk;

    fft4_stream #(.DW(DW), .SCALE_EN(1'b0), .TAG_W(TAG_W)) dutFull (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_inv(in_inv),
        .in_tag(in_tag), .in_x(in_x), .out_valid(ov0), .out_ready(out_ready),
        .out_X(x0Out), .out_inv(inv0), .out_tag(tag0), .out_ovf(ovf0));

    fft4_stream #(.DW(DW), .SCALE_EN(1'b1), .TAG_W(TAG_W)) dutScaled (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_inv(in_inv),
        .in_tag(in_tag), .in_x(in_x), .out_valid(ov1), .out_ready(out_ready),
        .out_X(x1Out), .out_inv(inv1), .out_tag(tag1), .out_ovf(ovf1));

    function automatic int comp(input logic [FW-1:0] v, input int c);
        logic signed [DW-1:0] s;
        s = v[c*DW +: DW];
        return int'(s);
    endfunction

    function automatic int clampDw(input int v, output logic clipped);
        clipped = (v > MAXV) || (v < MINV);
        return (v > MAXV) ? MAXV : ((v < MINV) ? MINV : v);
    endfunction

    function automatic void rotPow(input int re, input int im, input int p, output int oRe, output int oIm);
        case (p & 3)
            0: begin oRe = re;  oIm = im;  end
            1: begin oRe = im;  oIm = -re; end
            2: begin oRe = -re; oIm = -im; end
            default: begin oRe = -im; oIm = re; end
        endcase
    endfunction

    // Direct DFT: X_k = sum_n x_n * w^(nk), w = -j forward, +j inverse, then clip to DW.
    function automatic exp_t modelFull(input logic [FW-1:0] x, input logic inv, input logic [TAG_W-1:0] tag);
        exp_t e;
        int accRe, accIm, tRe, tIm, p, vRe, vIm;
        logic cRe, cIm;
        e.x = '0; e.ovf = 1'b0; e.inv = inv; e.tag = tag;
        for (int k = 0; k < 4; k++) begin
            accRe = 0; accIm = 0;
            for (int n = 0; n < 4; n++) begin
                p = (n * k) % 4;
                if (inv) p = (4 - p) % 4;
                rotPow(comp(x, 2*n), comp(x, 2*n+1), p, tRe, tIm);
                accRe += tRe; accIm += tIm;
            end
            vRe = clampDw(accRe, cRe);
            vIm = clampDw(accIm, cIm);
            e.x[(2*k)*DW +: DW]   = DW'(vRe);
            e.x[(2*k+1)*DW +: DW] = DW'(vIm);
            e.ovf = e.ovf | cRe | cIm;
        end
        return e;
    endfunction

    function automatic int halve(input int v);
        logic unused;
        return clampDw((v + 1) >>> 1, unused);
    endfunction

    // Two radix-2 passes, each sum rounded half-up and halved.
    function automatic exp_t modelScaled(input logic [FW-1:0] x, input logic inv, input logic [TAG_W-1:0] tag);
        exp_t e;
        int r[8];
        int y[8];
        int aR, aI, bR, bI, cR, cI, dR, dI, wR, wI;
        for (int c = 0; c < 8; c++) r[c] = comp(x, c);
        aR = halve(r[0] + r[4]); aI = halve(r[1] + r[5]);
        bR = halve(r[0] - r[4]); bI = halve(r[1] - r[5]);
        cR = halve(r[2] + r[6]); cI = halve(r[3] + r[7]);
        dR = halve(r[2] - r[6]); dI = halve(r[3] - r[7]);
        rotPow(dR, dI, inv ? 3 : 1, wR, wI);
        y[0] = halve(aR + cR); y[1] = halve(aI + cI);
        y[4] = halve(aR - cR); y[5] = halve(aI - cI);
        y[2] = halve(bR + wR); y[3] = halve(bI + wI);
        y[6] = halve(bR - wR); y[7] = halve(bI - wI);
        e.x = '0; e.ovf = 1'b0; e.inv = inv; e.tag = tag;
        for (int c = 0; c < 8; c++) e.x[c*DW +: DW] = DW'(y[c]);
        return e;
    endfunction

    function automatic logic [FW-1:0] frame4(input int r0, input int i0, input int r1, input int i1,
                                             input int r2, input int i2, input int r3, input int i3);
        logic [FW-1:0] f;
        f = {DW'(i3), DW'(r3), DW'(i2), DW'(r2), DW'(i1), DW'(r1), DW'(i0), DW'(r0)};
        return f;
    endfunction

    function automatic logic [FW-1:0] randFrame();
        logic [FW-1:0] f;
        int s;
        for (int c = 0; c < 8; c++) begin
            s = int'($urandom_range(0, 9));
            if (s == 0)      f[c*DW +: DW] = DW'(MINV);
            else if (s == 1) f[c*DW +: DW] = DW'(MAXV);
            else             f[c*DW +: DW] = DW'($urandom);
        end
        return f;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic checkFrame(input string name, input exp_t e, input logic [FW-1:0] x,
                              input logic inv, input logic [TAG_W-1:0] tag, input logic ovf);
        total++;
        if (x !== e.x || inv !== e.inv || tag !== e.tag || ovf !== e.ovf) begin
            bad++;
            $display("[TB] FAIL %s: got X=%h inv=%0b tag=%0d ovf=%0b, want X=%h inv=%0b tag=%0d ovf=%0b",
                     name, x, inv, tag, ovf, e.x, e.inv, e.tag, e.ovf);
        end
    endtask

    task automatic checkBins(input string name, input logic [FW-1:0] v, input int e[8]);
        for (int c = 0; c < 8; c++) checkOutput($sformatf("%s_c%0d", name, c), comp(v, c), e[c]);
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the frame.
    task automatic applyStimulus(input logic [FW-1:0] x, input logic inv, input logic [TAG_W-1:0] tag);
        logic accepted;
        accepted = 1'b0;
        in_valid = 1'b1; in_x = x; in_inv = inv; in_tag = tag;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk);
            accepted = rdy0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            total++; bad++;
            $display("[TB] FAIL handshake_timeout: got no in_ready in 200 cycles, want in_ready=1");
        end
    endtask

    // Counts edges from the accepting edge (1) to the edge after which out_valid shows.
    task automatic waitOutput(input string name);
        int lat;
        bit seen;
        lat = 1; seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (ov0) seen = 1'b1;
            else begin @(posedge clk); #1; lat++; end
        end
        checkOutput({name, "_latency"}, seen ? lat : -1, 3);
    endtask

    task automatic drainAll(input string name);
        out_ready = 1'b1;
        for (int i = 0; i < 100 && (q0.size() != 0 || q1.size() != 0); i++) begin
            @(posedge clk); #1;
        end
        checkOutput({name, "_drained"}, q0.size() + q1.size(), 0);
    endtask

    // Scoreboard: model frames queued at input handshake, popped at output handshake.
    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("stall_valid_held", int'(ov0), 1);
                total++;
                if (x0Out !== prevX || tag0 !== prevTag) begin
                    bad++;
                    $display("[TB] FAIL stall_data_held: got X=%h tag=%0d, want X=%h tag=%0d",
                             x0Out, tag0, prevX, prevTag);
                end
            end
            if (ov0 && out_ready) begin
                if (q0.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL full_unexpected: got frame tag=%0d, want none", tag0);
                end else checkFrame("full_frame", q0.pop_front(), x0Out, inv0, tag0, ovf0);
                tagLog.push_back(tag0);
            end
            if (ov1 && out_ready) begin
                if (q1.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL scaled_unexpected: got frame tag=%0d, want none", tag1);
                end else checkFrame("scaled_frame", q1.pop_front(), x1Out, inv1, tag1, ovf1);
            end
            if (in_valid && rdy0) q0.push_back(modelFull(in_x, in_inv, in_tag));
            if (in_valid && rdy1) q1.push_back(modelScaled(in_x, in_inv, in_tag));
            prevStall = ov0 && !out_ready;
            prevX     = x0Out;
            prevTag   = tag0;
        end
    end

    initial begin
        int ghost;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", int'(ov0), 0);
        checkOutput("rst_out_valid_scaled", int'(ov1), 0);
        checkOutput("rst_out_x_zero", int'(x0Out == '0), 1);
        checkOutput("rst_out_tag", int'(tag0), 0);
        checkOutput("rst_out_inv", int'(inv0), 0);
        checkOutput("rst_out_ovf", int'(ovf0), 0);
        checkOutput("rst_in_ready", int'(rdy0), 1);
        @(posedge clk); #1;

        // Impulse at x0: flat spectrum.
        applyStimulus(frame4(1000, 0, 0, 0, 0, 0, 0, 0), 1'b0, 4'd1);
        waitOutput("t1");
        checkBins("t1_full", x0Out, '{1000, 0, 1000, 0, 1000, 0, 1000, 0});
        checkOutput("t1_ovf", int'(ovf0), 0);
        @(posedge clk); #1;

        // Impulse at x1: forward and inverse twiddles.
        applyStimulus(frame4(0, 0, 1000, 0, 0, 0, 0, 0), 1'b0, 4'd2);
        waitOutput("t2f");
        checkBins("t2f_full", x0Out, '{1000, 0, 0, -1000, -1000, 0, 0, 1000});
        @(posedge clk); #1;
        applyStimulus(frame4(0, 0, 1000, 0, 0, 0, 0, 0), 1'b1, 4'd3);
        waitOutput("t2i");
        checkBins("t2i_full", x0Out, '{1000, 0, 0, 1000, -1000, 0, 0, -1000});
        checkOutput("t2i_inv", int'(inv0), 1);
        @(posedge clk); #1;

        // DC input, full growth and scaled; then saturating DC.
        applyStimulus(frame4(1000, 0, 1000, 0, 1000, 0, 1000, 0), 1'b0, 4'd4);
        waitOutput("t3");
        checkBins("t3_full", x0Out, '{4000, 0, 0, 0, 0, 0, 0, 0});
        checkBins("t4_scaled", x1Out, '{1000, 0, 0, 0, 0, 0, 0, 0});
        @(posedge clk); #1;
        applyStimulus(frame4(32767, 0, 32767, 0, 32767, 0, 32767, 0), 1'b0, 4'd5);
        waitOutput("t3s");
        checkBins("t3s_full", x0Out, '{32767, 0, 0, 0, 0, 0, 0, 0});
        checkOutput("t3s_ovf", int'(ovf0), 1);
        checkOutput("t3s_ovf_scaled", int'(ovf1), 0);
        @(posedge clk); #1;

        // Rounding in the scaled path.
        applyStimulus(frame4(3, 0, 0, 0, 0, 0, 0, 0), 1'b0, 4'd6);
        waitOutput("t4r");
        checkBins("t4r_scaled", x1Out, '{1, 0, 1, 0, 1, 0, 1, 0});
        @(posedge clk); #1;
        drainAll("directed");

        // Six back-to-back frames with a 5-cycle output stall in the middle.
        tagLog.delete();
        fork
            begin
                for (int t = 1; t <= 6; t++) applyStimulus(randFrame(), 1'($urandom_range(0, 1)), TAG_W'(t));
            end
            begin
                for (int i = 0; i < 20 && !ov0; i++) @(negedge clk);
                @(posedge clk); #1;
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    checkOutput("t5_in_ready_stalled", int'(rdy0), 0);
                    checkOutput("t5_out_valid_stalled", int'(ov0), 1);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drainAll("t5");
        checkOutput("t5_frame_count", tagLog.size(), 6);
        for (int i = 0; i < tagLog.size() && i < 6; i++)
            checkOutput($sformatf("t5_tag_order_%0d", i), int'(tagLog[i]), i + 1);

        // Reset with three frames in flight.
        for (int t = 7; t <= 9; t++) applyStimulus(randFrame(), 1'b0, TAG_W'(t));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t6_out_valid", int'(ov0), 0);
        checkOutput("t6_out_valid_scaled", int'(ov1), 0);
        checkOutput("t6_in_ready", int'(rdy0), 1);
        ghost = 0;
        repeat (10) begin
            @(negedge clk);
            if (ov0 || ov1) ghost++;
        end
        checkOutput("t6_no_ghost_frames", ghost, 0);
        @(posedge clk); #1;

        // Constrained-random traffic with random gaps and backpressure.
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
                    end
                    applyStimulus(randFrame(), 1'($urandom_range(0, 1)), TAG_W'(i));
                end
                randDone = 1'b1;
            end
            begin
                while (!randDone) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drainAll("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
